// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - signal bundle between the reset sequencer, the PLL conduit and the SoC
//
// Ports (slave = sequencer side):
//   pll_locked     PLL lock conduit, asynchronous to the sequencer clock
//   sw_reset_req   single-cycle software request to reset the SoC only
//   pll_areset     PLL reset, active-high
//   soc_reset_n    SoC reset, active-low
//   seq_fail       sticky: lock was never achieved within the retry budget
//   seq_state      current sequencer state, for debug
//   lock_loss_cnt  saturating count of lock losses seen after lock was accepted

interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_areset;
    logic       soc_reset_n;
    logic       seq_fail;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output pll_areset,
        output soc_reset_n,
        output seq_fail,
        output seq_state,
        output lock_loss_cnt
    );

    modport master (
        output pll_locked,
        output sw_reset_req,
        input  pll_areset,
        input  soc_reset_n,
        input  seq_fail,
        input  seq_state,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL areset / SoC reset sequencer with lock filtering, retries and failure report
//
// Ports:
//   EXT_CLK_50M  sole clock (board oscillator)
//   RESET        asynchronous active-high reset
//   bus          pll_reset_sequencer_if.slave (lock conduit, sw reset request, reset outputs, status)
//
// Sequence: S_POR pulses pll_areset for POR_CYCLES, S_WAIT_LOCK waits for a filtered
// lock (retrying up to MAX_RETRIES timeouts, then S_FAIL), S_HOLD keeps the SoC in
// reset for HOLD_CYCLES, S_RUN releases it. Losing lock after acceptance restarts
// the whole sequence; a software request in S_RUN only replays S_HOLD.

module pll_reset_sequencer #(
    parameter int POR_CYCLES          = 127,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_FILTER         = 16,
    parameter int HOLD_CYCLES         = 256,
    parameter int MAX_RETRIES         = 3
) (
    input logic                  EXT_CLK_50M,
    input logic                  RESET,
    pll_reset_sequencer_if.slave bus
);

    localparam int POR_W   = $clog2(POR_CYCLES) + 1;
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int FILT_W  = $clog2(LOCK_FILTER) + 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES) + 1;

    // Terminal values: a phase ends on the edge where its counter holds N-1,
    // so the phase spans exactly N edges from entry.
    localparam logic [POR_W-1:0]   POR_LAST   = POR_W'(POR_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [FILT_W-1:0]  FILT_MAX   = FILT_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_POR       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 lock_meta;
    logic                 lock_s;
    logic [FILT_W-1:0]    filt_cnt;
    logic [POR_W-1:0]     por_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [7:0]           loss_cnt;

    logic                 pll_areset_q;
    logic                 soc_reset_n_q;
    logic                 seq_fail_q;

    logic                 filt_done;
    logic                 loss_evt;
    logic                 tmo_evt;

    // Lock is accepted on the edge that samples the LOCK_FILTER-th consecutive
    // high lock_s. The filter saturates rather than wrapping, so a lock that was
    // already stable before S_WAIT_LOCK is accepted on the first waiting edge.
    assign filt_done = lock_s && (filt_cnt >= FILT_LAST);

    always_comb begin
        state_nxt = state;
        loss_evt  = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            S_POR: begin
                if (por_cnt == POR_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock acceptance wins over a timeout landing on the same edge.
                if (filt_done) begin
                    state_nxt = S_HOLD;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_evt   = 1'b1;
                    state_nxt = (retry_cnt == RETRY_LAST) ? S_FAIL : S_POR;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    loss_evt  = 1'b1;
                    state_nxt = S_POR;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Lock loss outranks a software request on the same edge.
                if (!lock_s) begin
                    loss_evt  = 1'b1;
                    state_nxt = S_POR;
                end else if (bus.sw_reset_req) begin
                    state_nxt = S_HOLD;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_POR;
            end
        endcase
    end

    always_ff @(posedge EXT_CLK_50M or posedge RESET) begin
        if (RESET) begin
            state         <= S_POR;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            filt_cnt      <= '0;
            por_cnt       <= '0;
            tmo_cnt       <= '0;
            hold_cnt      <= '0;
            retry_cnt     <= '0;
            loss_cnt      <= '0;
            pll_areset_q  <= 1'b1;
            soc_reset_n_q <= 1'b0;
            seq_fail_q    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;

            if (!lock_s) begin
                filt_cnt <= '0;
            end else if (filt_cnt != FILT_MAX) begin
                filt_cnt <= filt_cnt + 1'b1;
            end

            state <= state_nxt;

            // Phase counters restart on every state entry, including the
            // S_RUN -> S_HOLD replay triggered by a software request.
            if (state_nxt != state) begin
                por_cnt  <= '0;
                tmo_cnt  <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    S_POR:       por_cnt  <= por_cnt + 1'b1;
                    S_WAIT_LOCK: tmo_cnt  <= tmo_cnt + 1'b1;
                    S_HOLD:      hold_cnt <= hold_cnt + 1'b1;
                    default:     ;
                endcase
            end

            if (tmo_evt) begin
                retry_cnt <= retry_cnt + 1'b1;
            end else if (state_nxt == S_RUN && state != S_RUN) begin
                retry_cnt <= '0;
            end

            if (loss_evt && loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end

            // Outputs are decoded from the next state so they move on the
            // same edge as the state register.
            pll_areset_q  <= (state_nxt == S_POR) || (state_nxt == S_FAIL);
            soc_reset_n_q <= (state_nxt == S_RUN);
            seq_fail_q    <= (state_nxt == S_FAIL);
        end
    end

    assign bus.pll_areset    = pll_areset_q;
    assign bus.soc_reset_n   = soc_reset_n_q;
    assign bus.seq_fail      = seq_fail_q;
    assign bus.seq_state     = state;
    assign bus.lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

    localparam int P = 8;
    localparam int T = 32;
    localparam int F = 4;
    localparam int H = 16;
    localparam int R = 2;

    localparam int SIG_AR  = 0;
    localparam int SIG_SOC = 1;
    localparam int SIG_ST  = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .POR_CYCLES         (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_FILTER        (F),
        .HOLD_CYCLES        (H),
        .MAX_RETRIES        (R)
    ) dut (
        .EXT_CLK_50M(clk),
        .RESET      (rst),
        .bus        (bus)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sample(input int which);
        case (which)
            SIG_AR:  return {31'd0, bus.pll_areset};
            SIG_SOC: return {31'd0, bus.soc_reset_n};
            default: return {29'd0, bus.seq_state};
        endcase
    endfunction

    task automatic wait_out(input int which, input int val, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (sample(which) == val) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic release_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic bring_to_run(output int n);
        int m;
        rst = 1'b1;
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;
        tick();
        release_reset();
        wait_out(SIG_AR, 0, 100, m);
        bus.pll_locked = 1'b1;
        wait_out(SIG_ST, 3, 200, n);
    endtask

    // Reference: with lock absent the sequencer runs R rounds of
    // (P cycles of areset, T cycles waiting) and then fails for good.
    function automatic logic exp_areset_no_lock(input int k);
        if (k >= R * (P + T)) return 1'b1;
        return ((k % (P + T)) < P) ? 1'b1 : 1'b0;
    endfunction

    task automatic test_reset();
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;
        rst = 1'b1;
        #2;
        tests++;
        if (bus.pll_areset !== 1'b1 || bus.soc_reset_n !== 1'b0 || bus.seq_fail !== 1'b0 ||
            bus.seq_state !== 3'd0 || bus.lock_loss_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_values: areset=%b soc_n=%b fail=%b state=%0d loss=%0d required 1 0 0 0 0",
                     bus.pll_areset, bus.soc_reset_n, bus.seq_fail, bus.seq_state, bus.lock_loss_cnt);
        end
        repeat (5) tick();
        tests++;
        if (bus.pll_areset !== 1'b1 || bus.seq_state !== 3'd0) begin
            fails++;
            $display("FAIL reset_held: areset=%b state=%0d required 1 0", bus.pll_areset, bus.seq_state);
        end
    endtask

    task automatic test_bringup();
        int n;
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        tick();
        release_reset();
        wait_out(SIG_AR, 0, 100, n);
        tests++;
        if (n !== P) begin
            fails++;
            $display("FAIL bringup_por_len: got %0d required %0d", n, P);
        end
        repeat (4) tick();
        tests++;
        if (bus.seq_state !== 3'd1 || bus.soc_reset_n !== 1'b0) begin
            fails++;
            $display("FAIL bringup_wait: state=%0d soc_n=%b required 1 0", bus.seq_state, bus.soc_reset_n);
        end
        bus.pll_locked = 1'b1;
        wait_out(SIG_SOC, 1, 200, n);
        tests++;
        if (n !== 2 + F + H) begin
            fails++;
            $display("FAIL bringup_latency: got %0d required %0d", n, 2 + F + H);
        end
        tests++;
        if (bus.seq_state !== 3'd3 || bus.lock_loss_cnt !== 8'd0 || bus.pll_areset !== 1'b0 || bus.seq_fail !== 1'b0) begin
            fails++;
            $display("FAIL bringup_run: state=%0d loss=%0d areset=%b fail=%b required 3 0 0 0",
                     bus.seq_state, bus.lock_loss_cnt, bus.pll_areset, bus.seq_fail);
        end
    endtask

    task automatic test_timeout();
        int bad_ar;
        int bad_soc;
        int bad_hold;
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        tick();
        release_reset();
        bad_ar  = 0;
        bad_soc = 0;
        for (int k = 1; k <= R * (P + T) + 20; k++) begin
            tick();
            if (bus.pll_areset !== exp_areset_no_lock(k)) bad_ar++;
            if (bus.soc_reset_n !== 1'b0) bad_soc++;
        end
        tests++;
        if (bad_ar != 0) begin
            fails++;
            $display("FAIL timeout_areset_trace: %0d cycles differ, required 0", bad_ar);
        end
        tests++;
        if (bad_soc != 0) begin
            fails++;
            $display("FAIL timeout_soc_low: %0d cycles with soc_n high, required 0", bad_soc);
        end
        // Neither lock nor software requests may leave the failure state.
        bad_hold = 0;
        for (int k = 0; k < 1000; k++) begin
            bus.pll_locked   = (k >= 100);
            bus.sw_reset_req = (k % 97 == 5);
            tick();
            if (bus.seq_state !== 3'd4 || bus.seq_fail !== 1'b1) bad_hold++;
        end
        bus.sw_reset_req = 1'b0;
        tests++;
        if (bad_hold != 0) begin
            fails++;
            $display("FAIL fail_sticky: %0d cycles outside fail state, required 0", bad_hold);
        end
        tests++;
        if (bus.seq_state !== 3'd4 || bus.seq_fail !== 1'b1 || bus.pll_areset !== 1'b1 || bus.soc_reset_n !== 1'b0) begin
            fails++;
            $display("FAIL fail_outputs: state=%0d fail=%b areset=%b soc_n=%b required 4 1 1 0",
                     bus.seq_state, bus.seq_fail, bus.pll_areset, bus.soc_reset_n);
        end
    endtask

    task automatic test_lock_glitch();
        int n;
        int npairs;
        int hi;
        int lo;
        int bad;
        for (int it = 0; it < 4; it++) begin
            rst = 1'b1;
            bus.pll_locked = 1'b0;
            tick();
            release_reset();
            wait_out(SIG_AR, 0, 100, n);
            bad    = 0;
            npairs = (it == 0) ? 1 : int'($urandom_range(1, 3));
            for (int p = 0; p < npairs; p++) begin
                hi = (it == 0) ? 3 : int'($urandom_range(1, F - 1));
                lo = (it == 0) ? 1 : int'($urandom_range(1, 3));
                bus.pll_locked = 1'b1;
                repeat (hi) begin
                    tick();
                    if (bus.seq_state !== 3'd1) bad++;
                end
                bus.pll_locked = 1'b0;
                repeat (lo) begin
                    tick();
                    if (bus.seq_state !== 3'd1) bad++;
                end
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL glitch_no_hold it%0d: %0d cycles left wait state, required 0", it, bad);
            end
            bus.pll_locked = 1'b1;
            wait_out(SIG_SOC, 1, 200, n);
            tests++;
            if (n !== 2 + F + H) begin
                fails++;
                $display("FAIL glitch_latency it%0d: got %0d required %0d", it, n, 2 + F + H);
            end
        end
    endtask

    task automatic test_lock_drop();
        int n;
        int total;
        bring_to_run(n);
        tests++;
        if (n < 0) begin
            fails++;
            $display("FAIL drop_setup: run state not reached, got %0d", n);
        end
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        wait_out(SIG_SOC, 0, 10, n);
        total = n + 1;
        tests++;
        if (n < 0 || total > 3) begin
            fails++;
            $display("FAIL drop_latency: got %0d edges required at most 3", total);
        end
        tests++;
        if (bus.lock_loss_cnt !== 8'd1 || bus.pll_areset !== 1'b1 || bus.seq_state !== 3'd0) begin
            fails++;
            $display("FAIL drop_state: loss=%0d areset=%b state=%0d required 1 1 0",
                     bus.lock_loss_cnt, bus.pll_areset, bus.seq_state);
        end
        wait_out(SIG_AR, 0, 50, n);
        tests++;
        if (n !== P) begin
            fails++;
            $display("FAIL drop_por_len: got %0d required %0d", n, P);
        end
        total = total + n;
        // Lock stayed good through the pulse, so one waiting edge then the full hold.
        wait_out(SIG_SOC, 1, 200, n);
        total = total + n;
        tests++;
        if (n < 0 || total !== 3 + P + 1 + H) begin
            fails++;
            $display("FAIL drop_resequence: got %0d edges required %0d", total, 3 + P + 1 + H);
        end
        tests++;
        if (bus.seq_state !== 3'd3 || bus.lock_loss_cnt !== 8'd1) begin
            fails++;
            $display("FAIL drop_back_run: state=%0d loss=%0d required 3 1", bus.seq_state, bus.lock_loss_cnt);
        end
    endtask

    task automatic test_sw_reset();
        int n;
        int low;
        int ar_bad;
        int o;
        bring_to_run(n);
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(1, 20)) tick();
            o = int'($urandom_range(1, 12));
            bus.sw_reset_req = 1'b1;
            tick();
            bus.sw_reset_req = 1'b0;
            tests++;
            if (bus.seq_state !== 3'd2 || bus.soc_reset_n !== 1'b0) begin
                fails++;
                $display("FAIL sw_enter_hold it%0d: state=%0d soc_n=%b required 2 0", it, bus.seq_state, bus.soc_reset_n);
            end
            low    = (bus.soc_reset_n === 1'b0) ? 1 : 0;
            ar_bad = (bus.pll_areset !== 1'b0) ? 1 : 0;
            for (int k = 1; k <= 40; k++) begin
                if (k == o) bus.sw_reset_req = 1'b1;
                tick();
                bus.sw_reset_req = 1'b0;
                if (bus.pll_areset !== 1'b0) ar_bad++;
                if (bus.soc_reset_n === 1'b0) low++;
                else break;
            end
            tests++;
            if (low !== H) begin
                fails++;
                $display("FAIL sw_low_len it%0d: got %0d required %0d", it, low, H);
            end
            tests++;
            if (ar_bad != 0 || bus.seq_state !== 3'd3) begin
                fails++;
                $display("FAIL sw_areset_quiet it%0d: areset cycles=%0d state=%0d required 0 3", it, ar_bad, bus.seq_state);
            end
        end
    endtask

    task automatic test_saturation_and_async_reset();
        int n;
        int target;
        logic [7:0] exp_loss;
        bring_to_run(n);
        exp_loss = 8'd0;
        for (int i = 1; i <= 256; i++) begin
            target = int'($urandom_range(2, 3));
            wait_out(SIG_ST, target, 200, n);
            tests++;
            if (n < 0) begin
                fails++;
                $display("FAIL sat_reach loss%0d: state %0d not reached, got %0d", i, target, bus.seq_state);
                break;
            end
            repeat ($urandom_range(0, 5)) tick();
            bus.pll_locked = 1'b0;
            tick();
            bus.pll_locked = 1'b1;
            wait_out(SIG_ST, 0, 10, n);
            if (exp_loss != 8'd255) exp_loss = exp_loss + 8'd1;
            tests++;
            if (n < 0 || bus.lock_loss_cnt !== exp_loss) begin
                fails++;
                $display("FAIL sat_count loss%0d: got %0d required %0d", i, bus.lock_loss_cnt, exp_loss);
            end
        end
        tests++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            fails++;
            $display("FAIL sat_final: got %0d required 255", bus.lock_loss_cnt);
        end
        wait_out(SIG_ST, 2, 200, n);
        repeat (3) tick();
        #4;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.pll_areset !== 1'b1 || bus.soc_reset_n !== 1'b0 || bus.seq_fail !== 1'b0 ||
            bus.seq_state !== 3'd0 || bus.lock_loss_cnt !== 8'd0) begin
            fails++;
            $display("FAIL async_reset_hold: areset=%b soc_n=%b fail=%b state=%0d loss=%0d required 1 0 0 0 0",
                     bus.pll_areset, bus.soc_reset_n, bus.seq_fail, bus.seq_state, bus.lock_loss_cnt);
        end
        tick();
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_lock_glitch();
        test_lock_drop();
        test_sw_reset();
        test_saturation_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the PLL reset and the SoC reset. Sits between the board reset input and the SoC clock/reset inputs.
- Drives the PLL areset. Consumes the PLL locked conduit.
- Releases the SoC reset only after lock has been stable for a filtered period. Re-runs the sequence on lock loss or on a software reset request.
- Gives up after a bounded number of lock timeouts and reports failure.

Parameters:
POR_CYCLES, 127, cycles pll_areset is held high on each (re)entry to S_POR
LOCK_TIMEOUT_CYCLES, 50000, max cycles in S_WAIT_LOCK before a retry (1 ms at 50 MHz)
LOCK_FILTER, 16, consecutive synchronized-high lock samples required to accept lock
HOLD_CYCLES, 256, cycles soc_reset_n is held low after lock is accepted
MAX_RETRIES, 3, lock timeouts tolerated before entering S_FAIL

Ports:
EXT_CLK_50M  in  1  sole clock, 50 MHz board oscillator
RESET  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked, asynchronous to EXT_CLK_50M
sw_reset_req  in  1  single-cycle request to reset the SoC only
pll_areset  out  1  PLL reset, active-high, registered
soc_reset_n  out  1  SoC reset, active-low, registered
seq_fail  out  1  sticky: lock never achieved
seq_state  out  3  current state encoding, for debug
lock_loss_cnt  out  8  saturating count of lock losses seen in S_HOLD or S_RUN

Behaviour:
- Reset (RESET=1, takes effect immediately):
  - state=S_POR, all counters 0, retry_cnt=0, lock_loss_cnt=0.
  - pll_areset=1, soc_reset_n=0, seq_fail=0.
- Lock synchronizer:
  - pll_locked passes through a 2-FF synchronizer → lock_s. Only lock_s is used.
  - Filter counter increments while lock_s=1 and clears on any lock_s=0.
- All outputs are registered from the next-state value, so each output changes on the same edge as its state transition.
- State encoding and transitions:
  - S_POR (0):
    - pll_areset=1, soc_reset_n=0.
    - Count POR_CYCLES edges → S_WAIT_LOCK. pll_areset is high for exactly POR_CYCLES cycles per entry.
  - S_WAIT_LOCK (1):
    - pll_areset=0, soc_reset_n=0.
    - Filter reaches LOCK_FILTER → S_HOLD.
    - Otherwise, timeout counter reaching LOCK_TIMEOUT_CYCLES → increment retry_cnt. If the new retry_cnt == MAX_RETRIES → S_FAIL, else → S_POR.
    - If filter completion and timeout fall on the same edge, lock wins.
  - S_HOLD (2):
    - soc_reset_n=0.
    - lock_s=0 → S_POR, lock_loss_cnt+1.
    - Otherwise, after HOLD_CYCLES edges → S_RUN.
  - S_RUN (3):
    - soc_reset_n=1. retry_cnt clears on entry.
    - lock_s=0 → S_POR, lock_loss_cnt+1. Lock loss has priority over sw_reset_req on the same edge.
    - sw_reset_req=1 → S_HOLD. pll_areset stays 0, hold counter restarts.
  - S_FAIL (4):
    - pll_areset=1, soc_reset_n=0, seq_fail=1.
    - Exit only via RESET.
- sw_reset_req is ignored in every state except S_RUN.
- lock_loss_cnt saturates at 255. It never wraps.
- Counter widths: each counter is $clog2 of its parameter + 1, sized so terminal compares never overflow.
- Latency from pll_locked rising (stable) to soc_reset_n rising: 2 + LOCK_FILTER + HOLD_CYCLES edges, exact.
- Latency from pll_locked falling to soc_reset_n falling: at most 3 edges (2 sync + 1 registered state).
- soc_reset_n deasserts synchronously to EXT_CLK_50M. It asserts asynchronously only via RESET.

Test Plan (POR_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, LOCK_FILTER=4, HOLD_CYCLES=16, MAX_RETRIES=2):
- Normal bring-up: release RESET; raise pll_locked 5 cycles after pll_areset falls → pll_areset high exactly 8 cycles; soc_reset_n rises exactly 22 edges after pll_locked rises; seq_state=3; lock_loss_cnt=0.
- Lock never asserts → two 8-cycle pll_areset pulses separated by 32-cycle waits; then seq_state=4, seq_fail=1, pll_areset=1, soc_reset_n=0; state held for 1000 cycles until RESET.
- Lock glitch in S_WAIT_LOCK (high 3 cycles, low 1, then stable high) → no S_HOLD until 4 consecutive lock_s highs; soc_reset_n rises 22 edges after the final rise.
- Lock drop in S_RUN for 1 cycle → soc_reset_n low within 3 edges; lock_loss_cnt=1; pll_areset pulses 8 cycles; full re-sequence back to S_RUN.
- sw_reset_req pulse in S_RUN → soc_reset_n low for exactly 16 cycles, pll_areset stays 0; the same pulse in S_HOLD is ignored.
- RESET asserted mid-S_HOLD, and separately 256 forced lock losses → outputs return to reset values without waiting for a clock edge; lock_loss_cnt saturates at 255.
